// File: rtl/led_pattern_driver_pkg.sv
// Shared encodings and config record for the LED pattern driver and its timing helper.
package led_pattern_driver_pkg;

  localparam int unsigned MS_COUNT_W     = 16;
  localparam int unsigned BLINK_BASE_BIT = 6;
  localparam int unsigned RATE_W         = 3;
  localparam int unsigned ADDR_W         = 4;
  // Storage width for brightness; PWM_BITS must not exceed it.
  localparam int unsigned LEVEL_MAX_W    = 8;

  typedef enum logic [1:0] {
    LED_OFF   = 2'd0,
    LED_ON    = 2'd1,
    LED_BLINK = 2'd2,
    LED_PWM   = 2'd3
  } led_mode_e;

  typedef struct packed {
    led_mode_e               mode;
    logic [RATE_W-1:0]       rate;
    logic [LEVEL_MAX_W-1:0]  level;
  } led_cfg_t;

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler producing a one-cycle tick every TICK_DIV clocks plus a free-running tick counter.
import led_pattern_driver_pkg::*;

module led_tick_gen #(
  parameter int unsigned TICK_DIV = 12000
) (
  input  logic                  fx2_clk,
  input  logic                  reset,
  output logic                  tick,
  output logic [MS_COUNT_W-1:0] ms_count
);

  localparam int unsigned PRESC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] presc_nxt_c;

  always_comb begin
    presc_nxt_c = presc + PRESC_W'(1);
    if (presc == PRESC_LAST) presc_nxt_c = '0;
  end

  // tick is registered from the next prescaler value so it is high exactly while presc == TICK_DIV-1.
  always_ff @(posedge fx2_clk or posedge reset) begin
    if (reset) begin
      presc    <= '0;
      tick     <= 1'b0;
      ms_count <= '0;
    end else begin
      presc <= presc_nxt_c;
      tick  <= (presc_nxt_c == PRESC_LAST);
      if (presc == PRESC_LAST) ms_count <= ms_count + MS_COUNT_W'(1);
    end
  end

endmodule

// File: rtl/led_pattern_driver.sv
// Per-LED off/on/blink/PWM driver with millisecond timebase.
// Optional activity blink-out enabled by defining LED_ACT_STRETCH_EN.
import led_pattern_driver_pkg::*;

module led_pattern_driver #(
  parameter int unsigned NUM_LEDS      = 8,
  parameter int unsigned TICK_DIV      = 12000,
  parameter int unsigned PWM_BITS      = 4,
  parameter int unsigned STRETCH_TICKS = 50
) (
  input  logic                  fx2_clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [1:0]            wr_mode,
  input  logic [RATE_W-1:0]     wr_rate,
  input  logic [PWM_BITS-1:0]   wr_level,
  input  logic [NUM_LEDS-1:0]   act_in,
  output logic [NUM_LEDS-1:0]   led_out,
  output logic                  tick,
  output logic [MS_COUNT_W-1:0] ms_count
);

  led_cfg_t              cfg [NUM_LEDS];
  logic [PWM_BITS-1:0]   pwm_cnt;
  logic [NUM_LEDS-1:0]   mode_out_c;
  logic [NUM_LEDS-1:0]   stretch_c;

  led_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .fx2_clk  (fx2_clk),
    .reset    (reset),
    .tick     (tick),
    .ms_count (ms_count)
  );

  // Config registers; out-of-range addresses match no index and are dropped.
  always_ff @(posedge fx2_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        cfg[i] <= '{mode: LED_OFF, rate: '0, level: '0};
      end
    end else if (wr_en) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (wr_addr == ADDR_W'(i)) begin
          cfg[i] <= '{mode: led_mode_e'(wr_mode), rate: wr_rate, level: LEVEL_MAX_W'(wr_level)};
        end
      end
    end
  end

  always_ff @(posedge fx2_clk or posedge reset) begin
    if (reset) pwm_cnt <= '0;
    else       pwm_cnt <= pwm_cnt + PWM_BITS'(1);
  end

  always_comb begin
    mode_out_c = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      case (cfg[i].mode)
        LED_OFF:   mode_out_c[i] = 1'b0;
        LED_ON:    mode_out_c[i] = 1'b1;
        LED_BLINK: mode_out_c[i] = ms_count[4'(BLINK_BASE_BIT) + 4'(cfg[i].rate)];
        LED_PWM:   mode_out_c[i] = (LEVEL_MAX_W'(pwm_cnt) < cfg[i].level);
        default:   mode_out_c[i] = 1'b0;
      endcase
    end
  end

`ifdef LED_ACT_STRETCH_EN
  localparam int unsigned STR_W = $clog2(STRETCH_TICKS + 1);

  logic [STR_W-1:0] str_cnt [NUM_LEDS];

  // A fresh activity pulse reloads the counter and takes priority over a tick decrement.
  always_ff @(posedge fx2_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_LEDS; i++) str_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (act_in[i])                         str_cnt[i] <= STR_W'(STRETCH_TICKS);
        else if (tick && (str_cnt[i] != '0))   str_cnt[i] <= str_cnt[i] - STR_W'(1);
      end
    end
  end

  always_comb begin
    stretch_c = '0;
    for (int i = 0; i < NUM_LEDS; i++) stretch_c[i] = (str_cnt[i] != '0);
  end
`else
  logic unused_act;
  assign unused_act = (^act_in) ^ (STRETCH_TICKS == 0);

  always_comb begin
    stretch_c = '0;
  end
`endif

  always_ff @(posedge fx2_clk or posedge reset) begin
    if (reset) led_out <= '0;
    else       led_out <= mode_out_c ^ stretch_c;
  end

endmodule

// File: tb/tb_led_pattern_driver.sv
// Directed bench for led_pattern_driver with TICK_DIV=4; covers LED_ACT_STRETCH_EN when defined.
module tb_led_pattern_driver;

  localparam int unsigned NUM_LEDS      = 8;
  localparam int unsigned TICK_DIV      = 4;
  localparam int unsigned PWM_BITS      = 4;
  localparam int unsigned STRETCH_TICKS = 3;

  logic                fx2_clk;
  logic                reset;
  logic                wr_en;
  logic [3:0]          wr_addr;
  logic [1:0]          wr_mode;
  logic [2:0]          wr_rate;
  logic [PWM_BITS-1:0] wr_level;
  logic [NUM_LEDS-1:0] act_in;
  logic [NUM_LEDS-1:0] led_out;
  logic                tick;
  logic [15:0]         ms_count;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  led_pattern_driver #(
    .NUM_LEDS      (NUM_LEDS),
    .TICK_DIV      (TICK_DIV),
    .PWM_BITS      (PWM_BITS),
    .STRETCH_TICKS (STRETCH_TICKS)
  ) dut (
    .fx2_clk  (fx2_clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_mode  (wr_mode),
    .wr_rate  (wr_rate),
    .wr_level (wr_level),
    .act_in   (act_in),
    .led_out  (led_out),
    .tick     (tick),
    .ms_count (ms_count)
  );

  initial fx2_clk = 1'b0;
  always #5 fx2_clk = ~fx2_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  // Advance n clocks, leaving the bench at the following falling edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge fx2_clk);
      @(negedge fx2_clk);
      cyc++;
    end
  endtask

  task automatic step_to(input int target);
    while (cyc < target) step(1);
  endtask

  task automatic cfg_write(input logic [3:0] addr, input logic [1:0] mode,
                           input logic [2:0] rate, input logic [PWM_BITS-1:0] level);
    wr_en    = 1'b1;
    wr_addr  = addr;
    wr_mode  = mode;
    wr_rate  = rate;
    wr_level = level;
    step(1);
    wr_en    = 1'b0;
  endtask

  initial begin
    int hi;
    reset    = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_mode  = '0;
    wr_rate  = '0;
    wr_level = '0;
    act_in   = '0;
    #1 reset = 1'b1;
    #2;
    chk("rst_led", 32'(led_out), 32'h0);
    chk("rst_tick", 32'(tick), 32'h0);
    chk("rst_ms", 32'(ms_count), 32'h0);
    @(negedge fx2_clk);
    @(negedge fx2_clk);
    reset = 1'b0;
    cyc   = 0;

    // Tick on cycles 3, 7, 11; ms_count steps after each.
    for (int k = 1; k <= 12; k++) begin
      step(1);
      chk("tick", 32'(tick), 32'((cyc % 4) == 3));
      chk("ms", 32'(ms_count), 32'(cyc / 4));
    end

    // Two-cycle write latency, observed with ON then OFF.
    cfg_write(4'd0, 2'd1, 3'd0, 4'd0);
    chk("wr_lat1", 32'(led_out), 32'h00);
    step(1);
    chk("wr_lat2", 32'(led_out), 32'h01);
    cfg_write(4'd0, 2'd0, 3'd0, 4'd0);
    chk("off_lat1", 32'(led_out), 32'h01);
    step(1);
    chk("off_lat2", 32'(led_out), 32'h00);

    // Blink rate 0 on LED2: toggles every 64 ticks.
    cfg_write(4'd2, 2'd2, 3'd0, 4'd0);
    step_to(256);
    chk("blink_ms64", 32'(ms_count), 32'd64);
    chk("blink_lo", 32'(led_out), 32'h00);
    step(1);
    chk("blink_rise", 32'(led_out), 32'h04);
    step_to(512);
    chk("blink_hi", 32'(led_out), 32'h04);
    step(1);
    chk("blink_fall", 32'(led_out), 32'h00);

    // Out-of-range addresses must not alias onto real channels.
    cfg_write(4'd9, 2'd1, 3'd0, 4'd0);
    cfg_write(4'd8, 2'd1, 3'd0, 4'd0);
    cfg_write(4'd15, 2'd1, 3'd0, 4'd0);
    step_to(518);
    chk("bad_addr", 32'(led_out), 32'h00);

    // PWM level 5 on LED5: lit while previous-cycle pwm_cnt < 5.
    cfg_write(4'd5, 2'd3, 3'd0, 4'd5);
    step_to(521);
    hi = 0;
    for (int j = 0; j < 32; j++) begin
      chk("pwm5", 32'(led_out[5]), 32'(((cyc - 1) % 16) < 5));
      if (j < 16) hi += int'(led_out[5]);
      step(1);
    end
    chk("pwm5_duty", 32'(hi), 32'd5);

    cfg_write(4'd5, 2'd3, 3'd0, 4'd0);
    step_to(556);
    hi = 0;
    for (int j = 0; j < 16; j++) begin
      hi += int'(led_out[5]);
      step(1);
    end
    chk("pwm0_duty", 32'(hi), 32'd0);

    // Async reset mid-blink while tick is high.
    cfg_write(4'd0, 2'd1, 3'd0, 4'd0);
    step_to(771);
    chk("pre_rst_led", 32'(led_out), 32'h05);
    chk("pre_rst_tick", 32'(tick), 32'h1);
    chk("pre_rst_ms", 32'(ms_count), 32'd192);
    #2 reset = 1'b1;
    #1;
    chk("arst_led", 32'(led_out), 32'h0);
    chk("arst_tick", 32'(tick), 32'h0);
    chk("arst_ms", 32'(ms_count), 32'h0);
    wr_en   = 1'b1;
    wr_addr = 4'd1;
    wr_mode = 2'd1;
    @(negedge fx2_clk);
    wr_en = 1'b0;
    reset = 1'b0;
    cyc   = 0;
    step(4);
    chk("post_rst_led", 32'(led_out), 32'h00);
    chk("post_rst_ms", 32'(ms_count), 32'd1);

`ifdef LED_ACT_STRETCH_EN
    cfg_write(4'd0, 2'd1, 3'd0, 4'd0);
    step_to(20);
    chk("act_pre", 32'(led_out[0]), 32'h1);
    act_in = 8'h01;
    step(1);
    act_in = 8'h00;
    chk("act_lat", 32'(led_out[0]), 32'h1);
    step(1);
    chk("act_start", 32'(led_out[0]), 32'h0);
    step_to(32);
    chk("act_hold", 32'(led_out[0]), 32'h0);
    step(1);
    chk("act_end", 32'(led_out[0]), 32'h1);

    step_to(36);
    act_in = 8'h01;
    step(1);
    act_in = 8'h00;
    step_to(44);
    act_in = 8'h01;
    step(1);
    act_in = 8'h00;
    step_to(49);
    chk("retrig_ext", 32'(led_out[0]), 32'h0);
    step_to(56);
    chk("retrig_hold", 32'(led_out[0]), 32'h0);
    step(1);
    chk("retrig_end", 32'(led_out[0]), 32'h1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
